// File: rtl/max7219_display_driver.sv
// MAX7219 SPI driver: programs the config registers once after reset, then sends
// the six stopwatch digits as 16-bit address/data frames on every update strobe.
module max7219_display_driver #(
  parameter int         CLK_DIV   = 2,
  parameter logic [3:0] INTENSITY = 4'h8
) (
  input  logic       clk,
  input  logic       res,
  input  logic       upd,
  input  logic [3:0] ces_0X,
  input  logic [3:0] ces_X0,
  input  logic [3:0] sec_0X,
  input  logic [2:0] sec_X0,
  input  logic [3:0] min_0X,
  input  logic [2:0] min_X0,
  output logic       spi_mosi,
  output logic       spi_sclk,
  output logic       spi_cs_n,
  output logic       busy
);

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_REFRESH = 2'd1, ST_IDLE = 2'd2} state_t;
  typedef enum logic [1:0] {F_LOAD = 2'd0, F_SHIFT = 2'd1, F_GAP = 2'd2} fstate_t;

  localparam logic [8:0] HALF_LAST   = 9'(CLK_DIV - 1);
  localparam logic [8:0] GAP_LAST    = 9'(2 * CLK_DIV - 1);
  localparam logic [3:0] LAST_INIT   = 4'd4;
  localparam logic [3:0] FIRST_DIGIT = 4'd5;
  localparam logic [3:0] LAST_FRAME  = 4'd10;

  // Frames 0..4 are the init words, 5..10 the digit registers 0x01..0x06.
  function automatic logic [15:0] frame_word(input logic [3:0] idx,
                                             input logic [3:0] c0, input logic [3:0] c1,
                                             input logic [3:0] s0, input logic [2:0] s1,
                                             input logic [3:0] m0, input logic [2:0] m1);
    case (idx)
      4'd0:    frame_word = 16'h0F00;
      4'd1:    frame_word = 16'h09FF;
      4'd2:    frame_word = 16'h0B05;
      4'd3:    frame_word = {8'h0A, 4'h0, INTENSITY};
      4'd4:    frame_word = 16'h0C01;
      4'd5:    frame_word = {8'h01, 4'b0000, c0};
      4'd6:    frame_word = {8'h02, 4'b0000, c1};
      4'd7:    frame_word = {8'h03, 4'b1000, s0};
      4'd8:    frame_word = {8'h04, 5'b00000, s1};
      4'd9:    frame_word = {8'h05, 4'b1000, m0};
      4'd10:   frame_word = {8'h06, 5'b00000, m1};
      default: frame_word = 16'h0000;
    endcase
  endfunction

  state_t      r_state, w_state;
  fstate_t     r_fstate, w_fstate;
  logic [3:0]  r_frame, w_frame;
  logic [8:0]  r_div, w_div;
  logic [3:0]  r_bit, w_bit;
  logic [14:0] r_shift, w_shift;
  logic        r_mosi, w_mosi, r_sclk, w_sclk, r_cs_n, w_cs_n;
  logic        r_busy, w_busy, r_pending, w_pending, w_snap;
  logic [3:0]  r_c0, r_c1, r_s0, r_m0, w_c0, w_c1, w_s0, w_m0;
  logic [2:0]  r_s1, r_m1, w_s1, w_m1;
  logic [3:0]  w_gap_idx;
  logic        w_gap_live;
  logic [15:0] w_load_word, w_gap_word;

  // The refresh that follows INIT, and any back-to-back refresh, samples the live inputs.
  assign w_gap_idx   = (r_frame == LAST_FRAME) ? FIRST_DIGIT : r_frame + 4'd1;
  assign w_gap_live  = (r_frame == LAST_INIT) || (r_frame == LAST_FRAME);
  assign w_load_word = frame_word(r_frame, r_c0, r_c1, r_s0, r_s1, r_m0, r_m1);
  assign w_gap_word  = w_gap_live
                     ? frame_word(w_gap_idx, ces_0X, ces_X0, sec_0X, sec_X0, min_0X, min_X0)
                     : frame_word(w_gap_idx, r_c0, r_c1, r_s0, r_s1, r_m0, r_m1);

  // Next-state logic for the sequence and frame machines.
  always_comb begin
    w_state  = r_state;
    w_fstate = r_fstate;
    w_frame  = r_frame;
    w_div    = r_div;
    w_bit    = r_bit;
    w_shift  = r_shift;
    w_mosi   = r_mosi;
    w_sclk   = r_sclk;
    w_cs_n   = r_cs_n;
    w_busy   = r_busy;
    w_snap   = 1'b0;
    if (upd && (r_state != ST_IDLE)) begin
      w_pending = 1'b1;
    end else begin
      w_pending = r_pending;
    end
    case (r_fstate)
      F_LOAD: begin
        if (r_state != ST_IDLE) begin
          w_fstate = F_SHIFT;
          w_cs_n   = 1'b0;
          w_sclk   = 1'b0;
          w_mosi   = w_load_word[15];
          w_shift  = w_load_word[14:0];
          w_bit    = 4'd15;
          w_div    = 9'd0;
          w_busy   = 1'b1;
        end else if (upd) begin
          w_state = ST_REFRESH;
          w_frame = FIRST_DIGIT;
          w_snap  = 1'b1;
        end else begin
          w_state = ST_IDLE;
        end
      end
      F_SHIFT: begin
        if (r_div != HALF_LAST) begin
          w_div = r_div + 9'd1;
        end else if (!r_sclk) begin
          w_div  = 9'd0;
          w_sclk = 1'b1;
        end else if (r_bit == 4'd0) begin
          w_div    = 9'd0;
          w_sclk   = 1'b0;
          w_cs_n   = 1'b1;
          w_mosi   = 1'b0;
          w_fstate = F_GAP;
        end else begin
          w_div   = 9'd0;
          w_sclk  = 1'b0;
          w_bit   = r_bit - 4'd1;
          w_mosi  = r_shift[14];
          w_shift = {r_shift[13:0], 1'b0};
        end
      end
      F_GAP: begin
        if (r_div != GAP_LAST) begin
          w_div = r_div + 9'd1;
        end else if ((r_frame == LAST_FRAME) && !r_pending && !upd) begin
          w_state  = ST_IDLE;
          w_fstate = F_LOAD;
          w_frame  = FIRST_DIGIT;
          w_div    = 9'd0;
          w_busy   = 1'b0;
        end else begin
          w_fstate = F_SHIFT;
          w_frame  = w_gap_idx;
          w_div    = 9'd0;
          w_bit    = 4'd15;
          w_cs_n   = 1'b0;
          w_mosi   = w_gap_word[15];
          w_shift  = w_gap_word[14:0];
          if (w_gap_live) begin
            w_state = ST_REFRESH;
            w_snap  = 1'b1;
          end else begin
            w_state = r_state;
          end
          if (r_frame == LAST_FRAME) begin
            w_pending = 1'b0;
          end else begin
            w_pending = w_pending;
          end
        end
      end
      default: w_fstate = F_LOAD;
    endcase
    w_c0 = w_snap ? ces_0X : r_c0;
    w_c1 = w_snap ? ces_X0 : r_c1;
    w_s0 = w_snap ? sec_0X : r_s0;
    w_s1 = w_snap ? sec_X0 : r_s1;
    w_m0 = w_snap ? min_0X : r_m0;
    w_m1 = w_snap ? min_X0 : r_m1;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_state   <= ST_INIT;
      r_fstate  <= F_LOAD;
      r_frame   <= 4'd0;
      r_div     <= 9'd0;
      r_bit     <= 4'd0;
      r_shift   <= 15'd0;
      r_mosi    <= 1'b0;
      r_sclk    <= 1'b0;
      r_cs_n    <= 1'b1;
      r_busy    <= 1'b1;
      r_pending <= 1'b0;
      r_c0      <= 4'd0;
      r_c1      <= 4'd0;
      r_s0      <= 4'd0;
      r_s1      <= 3'd0;
      r_m0      <= 4'd0;
      r_m1      <= 3'd0;
    end else begin
      r_state   <= w_state;
      r_fstate  <= w_fstate;
      r_frame   <= w_frame;
      r_div     <= w_div;
      r_bit     <= w_bit;
      r_shift   <= w_shift;
      r_mosi    <= w_mosi;
      r_sclk    <= w_sclk;
      r_cs_n    <= w_cs_n;
      r_busy    <= w_busy;
      r_pending <= w_pending;
      r_c0      <= w_c0;
      r_c1      <= w_c1;
      r_s0      <= w_s0;
      r_s1      <= w_s1;
      r_m0      <= w_m0;
      r_m1      <= w_m1;
    end
  end

  assign spi_mosi = r_mosi;
  assign spi_sclk = r_sclk;
  assign spi_cs_n = r_cs_n;
  assign busy     = r_busy;

endmodule

// File: tb/tb_max7219_display_driver.sv
// Directed bench for max7219_display_driver: decodes the SPI stream of a CLK_DIV=2
// instance and checks frame timing of CLK_DIV=1 and CLK_DIV=3 instances.
module tb_max7219_display_driver;

  localparam logic [79:0] INIT_W = 80'h0F00_09FF_0B05_0A08_0C01;
  localparam logic [95:0] ZERO_W = 96'h0100_0200_0380_0400_0580_0600;
  localparam logic [95:0] D1_W   = 96'h0102_0204_0389_0405_0587_0603;
  localparam logic [95:0] D2_W   = 96'h010C_0208_0386_0404_0580_0605;
  localparam logic [95:0] D3_W   = 96'h0101_0200_0380_0400_0589_0607;

  logic       clk = 1'b0;
  logic       res = 1'b1;
  logic       res_h = 1'b1;
  logic       upd = 1'b0;
  logic [3:0] ces_0X = 4'd0, ces_X0 = 4'd0, sec_0X = 4'd0, min_0X = 4'd0;
  logic [2:0] sec_X0 = 3'd0, min_X0 = 3'd0;
  logic       mosi, sclk, cs_n, busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  logic [15:0] words[$];
  int          falls[$];
  int          rises[$];
  logic [15:0] m_sh = 16'h0;
  int          m_fall = 0;
  logic        p_cs = 1'b1, p_sclk = 1'b0;

  always #5 clk = ~clk;

  max7219_display_driver #(.CLK_DIV(2), .INTENSITY(4'h8)) u_dut (
    .clk(clk), .res(res), .upd(upd),
    .ces_0X(ces_0X), .ces_X0(ces_X0), .sec_0X(sec_0X), .sec_X0(sec_X0),
    .min_0X(min_0X), .min_X0(min_X0),
    .spi_mosi(mosi), .spi_sclk(sclk), .spi_cs_n(cs_n), .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Decode frames of the main instance; sclk rises only while cs_n is low.
  always @(negedge clk) begin
    if (!cs_n && p_cs) begin
      m_sh   <= 16'h0;
      m_fall <= cyc;
    end else if (!cs_n && !p_sclk && sclk) begin
      m_sh <= {m_sh[14:0], mosi};
    end else if (cs_n && !p_cs) begin
      words.push_back(m_sh);
      falls.push_back(m_fall);
      rises.push_back(cyc);
    end
    p_cs   <= cs_n;
    p_sclk <= sclk;
  end

  for (genvar g = 0; g < 2; g++) begin : gen_h
    localparam int HD = (g == 0) ? 1 : 3;
    logic h_mosi, h_sclk, h_cs_n, h_busy;
    int   frames = 0, bad_len = 0, bad_gap = 0, bad_stab = 0;
    int   low_cnt = 0, gap_cnt = 0, rise_cnt = 0;
    logic q_cs = 1'b1, q_sclk = 1'b0, q_mosi = 1'b0, in_gap = 1'b0;

    max7219_display_driver #(.CLK_DIV(HD), .INTENSITY(4'h8)) u_h (
      .clk(clk), .res(res_h), .upd(1'b0),
      .ces_0X(4'h0), .ces_X0(4'h0), .sec_0X(4'h0), .sec_X0(3'h0),
      .min_0X(4'h0), .min_X0(3'h0),
      .spi_mosi(h_mosi), .spi_sclk(h_sclk), .spi_cs_n(h_cs_n), .busy(h_busy)
    );

    always @(negedge clk) begin
      if (!h_cs_n && q_cs) begin
        low_cnt  <= 1;
        rise_cnt <= 0;
        in_gap   <= 1'b0;
        if (in_gap && gap_cnt != 2 * HD) bad_gap <= bad_gap + 1;
      end else if (!h_cs_n) begin
        low_cnt <= low_cnt + 1;
        if (!q_sclk && h_sclk) begin
          rise_cnt <= rise_cnt + 1;
          if (h_mosi !== q_mosi) bad_stab <= bad_stab + 1;
        end
      end else if (!q_cs) begin
        frames  <= frames + 1;
        in_gap  <= 1'b1;
        gap_cnt <= 1;
        if (low_cnt != 32 * HD || rise_cnt != 16) bad_len <= bad_len + 1;
      end else if (in_gap) begin
        gap_cnt <= gap_cnt + 1;
      end
      q_cs   <= h_cs_n;
      q_sclk <= h_sclk;
      q_mosi <= h_mosi;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_batch(input string tag, input int base, input int n, input logic [95:0] exp);
    logic [15:0] got;
    for (int i = 0; i < n; i++) begin
      got = (base + i < words.size()) ? words[base + i] : 16'hDEAD;
      check($sformatf("%s_w%0d", tag, i), {16'h0, got}, {16'h0, exp[95 - 16 * i -: 16]});
    end
  endtask

  task automatic set_digits(input logic [2:0] m1, input logic [3:0] m0, input logic [2:0] s1,
                            input logic [3:0] s0, input logic [3:0] c1, input logic [3:0] c0);
    min_X0 = m1; min_0X = m0; sec_X0 = s1; sec_0X = s0; ces_X0 = c1; ces_0X = c0;
  endtask

  task automatic clear_log();
    words.delete();
    falls.delete();
    rises.delete();
  endtask

  // Waits for busy to drop; returns the edge index at which it was seen low.
  task automatic wait_idle(input int max_cyc, input bit churn, output int t_done);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      if (churn) begin
        set_digits(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                   4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end
      @(posedge clk);
      #1;
      n++;
    end
    check("busy_timeout", {31'd0, busy}, 32'd0);
    t_done = cyc;
  endtask

  initial begin
    int t;
    int k;

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs_n", {31'd0, cs_n}, 32'd1);
    check("rst_sclk", {31'd0, sclk}, 32'd0);
    check("rst_mosi", {31'd0, mosi}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);

    // INIT plus trailing refresh of zero digits
    @(negedge clk);
    res = 1'b0;
    res_h = 1'b0;
    clear_log();
    @(posedge clk);
    #1;
    check("first_cs_fall", {31'd0, cs_n}, 32'd0);
    check("first_busy", {31'd0, busy}, 32'd1);
    wait_idle(2000, 1'b0, t);
    check("init_len", t - falls[0], 32'd748);
    check("init_count", words.size(), 32'd11);
    check_batch("init", 0, 5, {INIT_W, 16'h0});
    check_batch("zero", 5, 6, ZERO_W);
    check("idle_sclk", {31'd0, sclk}, 32'd0);
    check("idle_mosi", {31'd0, mosi}, 32'd0);

    // Refresh from IDLE: cs_n falls one cycle after upd is sampled
    clear_log();
    @(negedge clk);
    set_digits(3'd3, 4'd7, 3'd5, 4'd9, 4'd4, 4'd2);
    upd = 1'b1;
    @(posedge clk);
    #1;
    check("upd_cs_hold", {31'd0, cs_n}, 32'd1);
    @(negedge clk);
    upd = 1'b0;
    @(posedge clk);
    #1;
    check("upd_cs_fall", {31'd0, cs_n}, 32'd0);
    check("upd_busy", {31'd0, busy}, 32'd1);
    wait_idle(2000, 1'b0, t);
    check("refresh_len", t - falls[0], 32'd408);
    check("d1_count", words.size(), 32'd6);
    check_batch("d1", 0, 6, D1_W);

    // Inputs churn every cycle after the snapshot; digit 0xC passes through
    clear_log();
    @(negedge clk);
    set_digits(3'd5, 4'd0, 3'd4, 4'd6, 4'd8, 4'hC);
    upd = 1'b1;
    @(posedge clk);
    @(negedge clk);
    upd = 1'b0;
    set_digits(3'd7, 4'hF, 3'd7, 4'hF, 4'hF, 4'hF);
    @(posedge clk);
    #1;
    wait_idle(2000, 1'b1, t);
    check("d2_count", words.size(), 32'd6);
    check_batch("d2", 0, 6, D2_W);

    // Three strobes during a refresh collapse into one back-to-back refresh
    clear_log();
    @(negedge clk);
    set_digits(3'd3, 4'd7, 3'd5, 4'd9, 4'd4, 4'd2);
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    set_digits(3'd7, 4'd9, 3'd0, 4'd0, 4'd0, 4'd1);
    repeat (60) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      repeat (10) @(negedge clk);
    end
    @(posedge clk);
    #1;
    wait_idle(3000, 1'b0, t);
    check("pend_count", words.size(), 32'd12);
    check_batch("pend_a", 0, 6, D1_W);
    check_batch("pend_b", 6, 6, D3_W);
    check("pend_gap", falls[6] - rises[5], 32'd4);
    check("pend_len", t - falls[0], 32'd816);

    // Asynchronous reset in the high phase of a bit, with a refresh pending
    clear_log();
    @(negedge clk);
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    repeat (40) @(negedge clk);
    upd = 1'b1;
    @(negedge clk);
    upd = 1'b0;
    k = 0;
    while (!(sclk && !cs_n) && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("mid_bit_found", {31'd0, sclk}, 32'd1);
    #1;
    res = 1'b1;
    #1;
    check("async_cs_n", {31'd0, cs_n}, 32'd1);
    check("async_sclk", {31'd0, sclk}, 32'd0);
    check("async_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    res = 1'b0;
    @(posedge clk);
    #1;
    clear_log();
    check("rerun_cs_fall", {31'd0, cs_n}, 32'd0);
    wait_idle(2000, 1'b0, t);
    check("rerun_len", t - falls[0], 32'd748);
    check_batch("rerun_init", 0, 5, {INIT_W, 16'h0});
    check_batch("rerun_d3", 5, 6, D3_W);
    repeat (100) @(posedge clk);
    #1;
    check("no_pending", words.size(), 32'd11);
    check("no_pending_busy", {31'd0, busy}, 32'd0);

    // Frame timing at CLK_DIV=1 and CLK_DIV=3 (their INIT finished long ago)
    check("h1_frames", gen_h[0].frames, 32'd11);
    check("h1_bad_len", gen_h[0].bad_len, 32'd0);
    check("h1_bad_gap", gen_h[0].bad_gap, 32'd0);
    check("h1_bad_stab", gen_h[0].bad_stab, 32'd0);
    check("h3_frames", gen_h[1].frames, 32'd11);
    check("h3_bad_len", gen_h[1].bad_len, 32'd0);
    check("h3_bad_gap", gen_h[1].bad_gap, 32'd0);
    check("h3_bad_stab", gen_h[1].bad_stab, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
